// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared sample width, idle output level and scheduler state codes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int SAMPLE_W = 11;

    localparam logic [SAMPLE_W-1:0] MIDSCALE_DEFAULT = 11'd1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module  : sample_fifo
// Brief   : Synchronous DEPTH-entry sample FIFO with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_fifo
    import pwm_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    // Guard both sides so a misbehaving caller cannot corrupt the count.
    assign w_push = push && (r_level != c_FULL_LEVEL);
    assign w_pop  = pop && (r_level != '0);

    assign head  = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (r_level == c_FULL_LEVEL);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_sample_scheduler.sv
// ============================================================================
// Module  : pwm_sample_scheduler
// Brief   : Buffers audio samples and releases one to the PWM stage per period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sample_scheduler
    import pwm_pkg::*;
#(
    parameter int                  DEPTH       = 16,
    parameter int                  PERIOD      = 2048,
    parameter int                  PRIME_LEVEL = 8,
    parameter logic [SAMPLE_W-1:0] MIDSCALE    = MIDSCALE_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [SAMPLE_W-1:0]      s_data,
    input  logic                     clear_underrun,
    output logic [SAMPLE_W-1:0]      pwm_value,
    output logic                     sample_strobe,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] c_CNT_LAST  = CW'(PERIOD - 1);
    localparam logic [LW-1:0] c_PRIME_LVL = LW'(PRIME_LEVEL);

    sched_state_t          r_state;
    logic [CW-1:0]         r_cnt;
    logic [SAMPLE_W-1:0]   r_pwm;
    logic                  r_strobe;
    logic                  r_underrun;

    logic                  w_full;
    logic [SAMPLE_W-1:0]   w_head;
    logic [LW-1:0]         w_level;
    logic                  w_due;
    logic                  w_pop;
    logic                  w_starve;

    assign s_ready = !w_full;

    // A disable in the same cycle as a due pop wins: nothing is consumed.
    assign w_due    = (r_state == ST_PLAY) && (r_cnt == c_CNT_LAST) && enable;
    assign w_pop    = w_due && (w_level != '0);
    assign w_starve = w_due && (w_level == '0);

    sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (w_pop),
        .head      (w_head),
        .level     (w_level),
        .full      (w_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pwm      <= MIDSCALE;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe <= 1'b0;

            if (w_starve) begin
                r_underrun <= 1'b1;
            end else if (clear_underrun) begin
                r_underrun <= 1'b0;
            end

            if (!enable) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_pwm   <= MIDSCALE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt   <= '0;
                        r_pwm   <= MIDSCALE;
                        r_state <= ST_PRIME;
                    end
                    ST_PRIME: begin
                        // Loading the last count makes the first pop land one cycle later.
                        if (w_level >= c_PRIME_LVL) begin
                            r_state <= ST_PLAY;
                            r_cnt   <= c_CNT_LAST;
                        end
                    end
                    ST_PLAY: begin
                        r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + CW'(1);
                        if (w_pop) begin
                            r_pwm    <= w_head;
                            r_strobe <= 1'b1;
                        end else if (w_starve) begin
                            r_state <= ST_PRIME;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_pwm   <= MIDSCALE;
                    end
                endcase
            end
        end
    end

    assign pwm_value     = r_pwm;
    assign sample_strobe = r_strobe;
    assign underrun      = r_underrun;
    assign level         = w_level;

endmodule

`default_nettype wire

// File: tb/tb_pwm_sample_scheduler.sv
// ============================================================================
// Module  : tb_pwm_sample_scheduler
// Brief   : Self-checking bench: vector table, scoreboard and corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_pwm_sample_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        s_valid;
    logic        s_ready;
    logic [10:0] s_data;
    logic        clear_underrun;
    logic [10:0] pwm_value;
    logic        sample_strobe;
    logic        underrun;
    logic [2:0]  level;

    int checks   = 0;
    int failures = 0;

    int sb[$];

    typedef struct {
        bit rst;
        bit en;
        bit v;
        int d;
        bit clr;
        int p;
        bit s;
        bit u;
        int l;
        bit r;
    } vec_t;

    vec_t vecs[$];

    pwm_sample_scheduler #(
        .DEPTH       (4),
        .PERIOD      (8),
        .PRIME_LEVEL (2),
        .MIDSCALE    (11'd1024)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .clear_underrun (clear_underrun),
        .pwm_value      (pwm_value),
        .sample_strobe  (sample_strobe),
        .underrun       (underrun),
        .level          (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(bit rst, bit en, bit v, int d, bit clr,
                                int p, bit s, bit u, int l, bit r);
        vec_t t;
        t.rst = rst; t.en = en; t.v = v; t.d = d; t.clr = clr;
        t.p = p; t.s = s; t.u = u; t.l = l; t.r = r;
        vecs.push_back(t);
    endfunction

    task automatic do_reset();
        enable = 1'b0;
        s_valid = 1'b0;
        clear_underrun = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_pwm", int'(pwm_value), 1024);
        check("rst_strobe", int'(sample_strobe), 0);
        check("rst_underrun", int'(underrun), 0);
        check("rst_level", int'(level), 0);
        check("rst_ready", int'(s_ready), 1);
        sb.delete();
        reset_n = 1'b1;
    endtask

    // Scoreboard: samples enter on an accepted handshake, leave on a strobe.
    always @(negedge clk) begin
        if (reset_n) begin
            if (sample_strobe) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: strobe with pwm_value %0d, expected no strobe", pwm_value);
                end else begin
                    check("sb_sample", int'(pwm_value), sb.pop_front());
                end
            end
            if (s_valid && s_ready) begin
                sb.push_back(int'(s_data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed;
        bit saw_full;
        bit rise_ok;
        bit done;

        // Idle with enable low: samples queue up, output stays parked.
        add(1, 0, 1,  10, 0, 1024, 0, 0, 1, 1);
        add(0, 0, 1,  20, 0, 1024, 0, 0, 2, 1);
        add(0, 0, 1,  30, 0, 1024, 0, 0, 3, 1);
        add(0, 0, 0,   0, 0, 1024, 0, 0, 3, 1);
        // Priming, first pop two cycles after level hits 2, next pop 8 later.
        add(1, 1, 1, 100, 0, 1024, 0, 0, 1, 1);
        add(0, 1, 1, 200, 0, 1024, 0, 0, 2, 1);
        add(0, 1, 0,   0, 0, 1024, 0, 0, 2, 1);
        add(0, 1, 0,   0, 0,  100, 1, 0, 1, 1);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, 100, 0, 0, 1, 1);
        add(0, 1, 0,   0, 0,  200, 1, 0, 0, 1);
        for (int i = 0; i < 7; i++) add(0, 1, 0, 0, 0, 200, 0, 0, 0, 1);
        // Underrun with a simultaneous clear: set must win.
        add(0, 1, 0,   0, 1,  200, 0, 1, 0, 1);
        add(0, 1, 1, 300, 0,  200, 0, 1, 1, 1);
        add(0, 1, 1, 400, 0,  200, 0, 1, 2, 1);
        add(0, 1, 0,   0, 0,  200, 0, 1, 2, 1);
        add(0, 1, 0,   0, 0,  300, 1, 1, 1, 1);
        add(0, 1, 0,   0, 1,  300, 0, 0, 1, 1);

        reset_n = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        clear_underrun = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            enable = vecs[i].en;
            s_valid = vecs[i].v;
            s_data = 11'(vecs[i].d);
            clear_underrun = vecs[i].clr;
            tick();
            check($sformatf("row%0d_pwm", i), int'(pwm_value), vecs[i].p);
            check($sformatf("row%0d_strobe", i), int'(sample_strobe), int'(vecs[i].s));
            check($sformatf("row%0d_underrun", i), int'(underrun), int'(vecs[i].u));
            check($sformatf("row%0d_level", i), int'(level), vecs[i].l);
            check($sformatf("row%0d_ready", i), int'(s_ready), int'(vecs[i].r));
        end
        clear_underrun = 1'b0;

        // Back-pressure: hold valid until five more samples are accepted.
        pushed = 0;
        saw_full = 0;
        rise_ok = 0;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            s_valid = (pushed < 5);
            s_data = 11'(500 + pushed);
            if (s_valid && s_ready) pushed++;
            tick();
            check("ready_vs_level", int'(s_ready), (level < 4) ? 1 : 0);
            if (level == 4) saw_full = 1;
            if (sample_strobe && saw_full && !rise_ok) begin
                check("ready_rise", int'(s_ready), 1);
                check("level_after_pop", int'(level), 3);
                rise_ok = 1;
            end
            if (pushed == 5 && sample_strobe && level == 2) done = 1;
        end
        s_valid = 1'b0;
        check("full_seq_done", int'(done), 1);
        check("full_seen", int'(saw_full), 1);
        check("full_rise_seen", int'(rise_ok), 1);

        // Disable mid-PLAY with two queued, then resume from PRIME.
        enable = 1'b0;
        tick();
        check("dis_pwm", int'(pwm_value), 1024);
        check("dis_level", int'(level), 2);
        check("dis_strobe", int'(sample_strobe), 0);
        repeat (3) tick();
        check("dis_hold_level", int'(level), 2);
        check("dis_hold_pwm", int'(pwm_value), 1024);
        enable = 1'b1;
        tick();
        check("reen_prime_strobe", int'(sample_strobe), 0);
        tick();
        check("reen_play_strobe", int'(sample_strobe), 0);
        tick();
        check("reen_pop_strobe", int'(sample_strobe), 1);
        check("reen_pop_pwm", int'(pwm_value), 503);
        check("reen_pop_level", int'(level), 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("reen_gap%0d_strobe", k), int'(sample_strobe), (k == 8) ? 1 : 0);
        end
        check("reen_second_pwm", int'(pwm_value), 504);
        check("reen_second_level", int'(level), 0);

        // Asynchronous reset mid-period with a sample queued.
        s_valid = 1'b1;
        s_data = 11'd700;
        tick();
        s_valid = 1'b0;
        check("pre_rst_level", int'(level), 1);
        tick();
        #1;
        reset_n = 1'b0;
        #1;
        check("arst_pwm", int'(pwm_value), 1024);
        check("arst_strobe", int'(sample_strobe), 0);
        check("arst_underrun", int'(underrun), 0);
        check("arst_level", int'(level), 0);
        check("arst_ready", int'(s_ready), 1);
        sb.delete();
        #1;
        reset_n = 1'b1;
        tick();
        check("post_rst_level", int'(level), 0);
        check("post_rst_pwm", int'(pwm_value), 1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
